// File: rtl/conv_window_ctrl.sv
// Sequencing controller for a KxK sliding-window line buffer: pixel handshake,
// shift enable, stride-aligned window flagging with output-map coordinates.
module conv_window_ctrl #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int K          = 5,
  parameter int STRIDE     = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          start,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic                          shift_en,
  input  logic                          win_ready,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_K     = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_K     = RW'(K - 1);
  localparam logic [RW-1:0] ROW_FILLD = RW'(K - 2);
  localparam logic [PW-1:0] PH_LAST   = PW'(STRIDE - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   col, wcol_cnt;
  logic [RW-1:0]   row, wrow_cnt;
  logic [PW-1:0]   cph, rph;
  logic            col_ok, row_ok, pos_ok;
  logic            col_wrap, last_pix, drain_exit, clear;

  // Phase counters hold (pos-(K-1)) mod STRIDE once the position reaches K-1
  assign col_ok     = (col >= COL_K) && (cph == '0);
  assign row_ok     = (row >= ROW_K) && (rph == '0);
  assign pos_ok     = col_ok && row_ok;
  assign col_wrap   = (col == COL_LAST);
  assign last_pix   = col_wrap && (row == ROW_LAST);
  assign pix_ready  = ((state == FILL) || (state == RUN)) && (!win_valid || win_ready);
  assign shift_en   = pix_valid && pix_ready;
  assign drain_exit = (state == DRAIN) && (!win_valid || win_ready);
  assign clear      = (state == IDLE) && start;
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = FILL;
      FILL, RUN: begin
        if (shift_en && last_pix)
          state_nxt = DRAIN;
        else if ((state == FILL) && shift_en && col_wrap && (row == ROW_FILLD))
          state_nxt = RUN;
      end
      DRAIN:    if (drain_exit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      col      <= '0;
      row      <= '0;
      cph      <= '0;
      rph      <= '0;
      wcol_cnt <= '0;
      wrow_cnt <= '0;
      win_row  <= '0;
      win_col  <= '0;
    end else if (clear) begin
      col      <= '0;
      row      <= '0;
      cph      <= '0;
      rph      <= '0;
      wcol_cnt <= '0;
      wrow_cnt <= '0;
      win_row  <= '0;
      win_col  <= '0;
    end else if (shift_en) begin
      if (pos_ok) begin
        win_row  <= wrow_cnt;
        win_col  <= wcol_cnt;
        wcol_cnt <= wcol_cnt + 1'b1;
      end
      if (col_wrap) begin
        col      <= '0;
        cph      <= '0;
        row      <= row + 1'b1;
        wcol_cnt <= '0;
        if (row_ok)
          wrow_cnt <= wrow_cnt + 1'b1;
        if (row >= ROW_K)
          rph <= (rph == PH_LAST) ? '0 : rph + 1'b1;
        else
          rph <= '0;
      end else begin
        col <= col + 1'b1;
        if (col >= COL_K)
          cph <= (cph == PH_LAST) ? '0 : cph + 1'b1;
        else
          cph <= '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= drain_exit;
      if (clear)
        win_valid <= 1'b0;
      else if (shift_en)
        win_valid <= pos_ok;
      else if (win_ready)
        win_valid <= 1'b0;
    end
  end

endmodule
